regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_rdport.sv | 36 +++
 rtl/regfile_multiport.sv | 84 ++++++++
 tb/tb_regfile_multiport.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport register file.
package regfile_pkg;
  localparam int RF_XLEN = 64;

  typedef enum logic {RF_IDLE, RF_CLEAR} regfile_state_t;

  localparam logic [RF_XLEN-1:0] RF_ZERO = '0;
endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero register, busy masking and optional write-first
// forwarding (enabled by defining REGFILE_BYPASS_EN).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [AW-1:0]              addr,
  input  logic                       busy,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  output logic [XLEN-1:0]            rd_data
);

  always_comb begin
    rd_data = regs[addr];
    if (busy || addr == '0) begin
      rd_data = XLEN'(RF_ZERO);
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && wr_addr == addr) begin
      rd_data = wr_data;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};
`endif

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with a sequential bank clear that also runs after reset.
// Optional write-first read forwarding: define REGFILE_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  input  logic                     regwrite,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_drop
);

  regfile_state_t              state, state_nxt;
  logic [AW-1:0]               cnt, cnt_nxt;
  logic [NREGS-1:0][XLEN-1:0]  mem;

  assign busy = (state == RF_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      cnt     <= AW'(1);
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_drop <= busy && regwrite && (wr_addr != '0);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          cnt_nxt   = AW'(1);
        end
      end
      RF_CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(NREGS-1)) state_nxt = RF_IDLE;
      end
      default: state_nxt = RF_CLEAR;
    endcase
  end

  // Storage is never reset; the clear walk after reset zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= XLEN'(RF_ZERO);
    end else if (regwrite && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rdport (
      .regs    (mem),
      .addr    (rd_addr[i]),
      .busy    (busy),
      .wr_en   (regwrite),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[i])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized scoreboard bench for regfile_multiport against an array-based reference model.
module tb_regfile_multiport;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NRD-1:0][AW-1:0]   rd_addr = '0;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic                     regwrite = 1'b0;
  logic [AW-1:0]            wr_addr = '0;
  logic [XLEN-1:0]          wr_data = '0;
  logic                     clr_req = 1'b0;
  logic                     busy;
  logic                     wr_drop;

  always #5 clk = ~clk;

  regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .regwrite (regwrite),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_drop  (wr_drop)
  );

  typedef struct {
    logic [NRD-1:0][XLEN-1:0] rd;
    logic                     busy;
    logic                     drop;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: register contents, cycles of clear left, pending drop flag.
  logic [XLEN-1:0] m [NREGS];
  int              clr_left = NREGS - 1;
  bit              drop_m = 1'b0;

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
  task automatic cyc(input bit rst, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input bit rw, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                     input bit clr);
    exp_t e;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    rst_n = rst; rd_addr[0] = a0; rd_addr[1] = a1;
    regwrite = rw; wr_addr = wa; wr_data = wd; clr_req = clr;
    if (!rst) begin
      clr_left = NREGS - 1;
      drop_m   = 1'b0;
    end
    e.busy = (clr_left > 0);
    e.drop = drop_m;
    for (int i = 0; i < NRD; i++) begin
      a = (i == 0) ? a0 : a1;
      if (e.busy || a == 0)             e.rd[i] = '0;
      else if (BYP && rw && wa == a)    e.rd[i] = wd;
      else                              e.rd[i] = m[a];
    end
    exp_q.push_back(e);
    if (!rst) begin
      m[1] = '0;
    end else if (clr_left > 0) begin
      m[NREGS - clr_left] = '0;
      clr_left--;
      drop_m = rw && (wa != 0);
    end else begin
      drop_m = 1'b0;
      if (rw && wa != 0) m[wa] = wd;
      if (clr) clr_left = NREGS - 1;
    end
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    cyc(1'b1, a0, a1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rand_cyc();
    logic [AW-1:0]   wa, a0, a1;
    logic [XLEN-1:0] wd;
    bit              rst;
    wa  = AW'($urandom);
    wd  = {$urandom, $urandom};
    a0  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
    a1  = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom);
    rst = ($urandom_range(0, 599) != 0);
    cyc(rst, a0, a1, 1'($urandom), wa, wd, ($urandom_range(0, 39) == 0));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (busy !== mon_e.busy) begin
        miscompares++;
        $display("FAIL busy vec %0d: got %b want %b", vectors, busy, mon_e.busy);
      end
      if (wr_drop !== mon_e.drop) begin
        miscompares++;
        $display("FAIL wr_drop vec %0d: got %b want %b", vectors, wr_drop, mon_e.drop);
      end
      for (int i = 0; i < NRD; i++) begin
        if (rd_data[i] !== mon_e.rd[i]) begin
          miscompares++;
          $display("FAIL rd_data[%0d] vec %0d addr %0d: got %h want %h",
                   i, vectors, rd_addr[i], rd_data[i], mon_e.rd[i]);
        end
      end
    end
  end

  initial begin
    // Held in reset, then the post-reset clear with a full read sweep after it.
    repeat (3) cyc(1'b0, 5'd1, 5'd2, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < NREGS - 1 + 2; k++) rd2(AW'(k), AW'(k + 1));
    for (int k = 0; k < NREGS; k++) rd2(AW'(k), AW'(k));

    // Plain write then read on both ports.
    cyc(1'b1, 5'd0, 5'd0, 1'b1, 5'd2, 64'h123456789ABCDEF0, 1'b0);
    rd2(5'd2, 5'd2);

    // Writes to register 0 vanish without a drop.
    cyc(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 64'hFFFF, 1'b0);
    rd2(5'd0, 5'd0);
    rd2(5'd0, 5'd2);

    // Same-cycle read of a register being written.
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 64'h77, 1'b0);
    cyc(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 64'hA5, 1'b0);
    rd2(5'd5, 5'd5);

    // Clear pulse with a write in the same cycle, then a dropped write two cycles later.
    cyc(1'b1, 5'd5, 5'd2, 1'b1, 5'd7, 64'hDEAD, 1'b1);
    rd2(5'd3, 5'd7);
    cyc(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 64'hBEEF, 1'b1);
    for (int k = 0; k < NREGS; k++) rd2(5'd3, 5'd7);
    rd2(5'd2, 5'd5);

    // Reset in the middle of a clear restarts the walk.
    cyc(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 64'h99, 1'b0);
    cyc(1'b1, 5'd9, 5'd9, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 10; k++) rd2(5'd9, 5'd1);
    cyc(1'b0, 5'd9, 5'd1, 1'b1, 5'd4, 64'h44, 1'b0);
    cyc(1'b0, 5'd9, 5'd1, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < NREGS + 2; k++) rd2(5'd9, AW'(k));

    for (int k = 0; k < 4000; k++) rand_cyc();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
